systolic_sequencer: RTL and testbench

SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

---
 rtl/systolic_ctrl_pkg.sv | 17 +
 rtl/en_delay_line.sv | 25 ++
 rtl/systolic_sequencer.sv | 132 +++++++++++++
 tb/tb_systolic_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_ctrl_pkg.sv
// Shared geometry, pipeline latency and FSM state encoding for the systolic
// array sequencer.
package systolic_ctrl_pkg;
  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int DW       = 8;
  localparam int PW       = 24;
  localparam int PIPE_LAT = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;
endpackage

// File: rtl/en_delay_line.sv
// Enable-gated shift register: q is d delayed by DEPTH enabled steps.
// Used for both the input skew and the output deskew of the array.
module en_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (en) begin
      r_stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q = r_stage[DEPTH-1];
endmodule

// File: rtl/systolic_sequencer.sv
// Sequencer for an external 4x4 weight-stationary systolic array: owns the
// weight bank, input skew, output deskew, result register and job FSM.
//
// state    | meaning
// IDLE     | bank writable, waiting for start
// LOAD_W   | one cycle pushing the bank into the array
// STREAM   | accepting input vectors until vec_count are taken
// DRAIN    | zero-injecting until the last result has been handed off
// DONE     | one-cycle done pulse
module systolic_sequencer
  import systolic_ctrl_pkg::*;
#(
  parameter int VEC_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [DW-1:0]         wr_data,
  input  logic                  start,
  input  logic [VEC_W-1:0]      vec_count,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*DW-1:0]    in_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [COLS*PW-1:0]    res_data,
  output logic                  arr_en,
  output logic                  arr_load_weight,
  output logic [ROWS*DW-1:0]    arr_ifmap,
  output logic [ROWS*COLS*DW-1:0] arr_weight,
  input  logic [COLS*PW-1:0]    arr_psum
);
  state_t               r_state, w_state_nxt;
  logic [DW-1:0]        r_bank [ROWS*COLS];
  logic [VEC_W-1:0]     r_remain;
  logic [PIPE_LAT-1:0]  r_vld;
  logic                 r_res_valid;
  logic [COLS*PW-1:0]   r_res_data;

  logic                 w_stall, w_accept, w_adv;
  logic [ROWS*DW-1:0]   w_inject;
  logic [COLS*PW-1:0]   w_aligned;

  assign w_stall  = r_res_valid & ~res_ready;
  assign w_accept = (r_state == S_STREAM) & in_valid & ~w_stall;
  assign w_adv    = w_accept | ((r_state == S_DRAIN) & ~w_stall);
  // Only accepted vectors enter the array; every other advance injects zeros.
  assign w_inject = w_accept ? in_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS*COLS; i++) r_bank[i] <= '0;
    end else if (r_state == S_IDLE && wr_en) begin
      r_bank[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < ROWS*COLS; i++) begin : g_wbus
    assign arr_weight[i*DW +: DW] = r_bank[i];
  end

  assign arr_ifmap[DW-1:0] = w_inject[DW-1:0];
  for (genvar r = 1; r < ROWS; r++) begin : g_skew
    en_delay_line #(.W(DW), .DEPTH(r)) u_skew (
      .clk(clk), .rst_n(rst_n), .en(w_adv),
      .d(w_inject[r*DW +: DW]), .q(arr_ifmap[r*DW +: DW])
    );
  end

  // Column c leaves the array c steps after column 0; delay it the rest of the way.
  for (genvar c = 0; c < COLS-1; c++) begin : g_deskew
    en_delay_line #(.W(PW), .DEPTH(COLS-1-c)) u_deskew (
      .clk(clk), .rst_n(rst_n), .en(w_adv),
      .d(arr_psum[c*PW +: PW]), .q(w_aligned[c*PW +: PW])
    );
  end
  assign w_aligned[(COLS-1)*PW +: PW] = arr_psum[(COLS-1)*PW +: PW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remain    <= '0;
      r_vld       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && start) r_remain <= vec_count;
      else if (w_accept)              r_remain <= r_remain - VEC_W'(1);
      if (w_adv) r_vld <= {r_vld[PIPE_LAT-2:0], w_accept};
      if (w_adv && r_vld[PIPE_LAT-1]) begin
        r_res_data  <= w_aligned;
        r_res_valid <= 1'b1;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    busy            = (r_state != S_IDLE);
    done            = 1'b0;
    in_ready        = 1'b0;
    arr_en          = w_adv;
    arr_load_weight = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_LOAD_W;
      S_LOAD_W: begin
        arr_en          = 1'b1;
        arr_load_weight = 1'b1;
        w_state_nxt     = (r_remain == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        in_ready = ~w_stall;
        if (w_accept && r_remain == VEC_W'(1)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN:  if (r_vld == '0 && !r_res_valid) w_state_nxt = S_DONE;
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer with a behavioural 4x4 weight-stationary
// array attached to the arr_* ports.
module tb_systolic_sequencer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic [7:0]   wr_data = '0;
  logic         start = 1'b0;
  logic [7:0]   vec_count = '0;
  logic         busy, done;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [95:0]  res_data;
  logic         arr_en, arr_load_weight;
  logic [31:0]  arr_ifmap;
  logic [127:0] arr_weight;
  logic [95:0]  arr_psum;

  int total = 0;
  int bad = 0;
  int n;
  logic seen_done;

  always #5 clk = ~clk;

  systolic_sequencer #(.VEC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .vec_count(vec_count), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .arr_en(arr_en), .arr_load_weight(arr_load_weight), .arr_ifmap(arr_ifmap),
    .arr_weight(arr_weight), .arr_psum(arr_psum)
  );

  // Array model: inputs move right, partial sums move down, one PE per step.
  logic signed [7:0]  m_w [4][4];
  logic signed [7:0]  m_a [4][4];
  logic signed [23:0] m_p [4][4];

  function automatic logic signed [7:0] a_in(int r, int c);
    if (c == 0) return arr_ifmap[8*r +: 8];
    return m_a[r][c-1];
  endfunction

  function automatic logic signed [23:0] p_in(int r, int c);
    if (r == 0) return 24'sd0;
    return m_p[r-1][c];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          m_w[r][c] <= '0; m_a[r][c] <= '0; m_p[r][c] <= '0;
        end
    end else if (arr_en) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (arr_load_weight) begin
            m_w[r][c] <= arr_weight[8*(r*4+c) +: 8];
            m_a[r][c] <= '0;
            m_p[r][c] <= '0;
          end else begin
            m_a[r][c] <= a_in(r, c);
            m_p[r][c] <= p_in(r, c) + 24'($signed(m_w[r][c]) * $signed(a_in(r, c)));
          end
        end
    end
  end

  assign arr_psum = {m_p[3][3], m_p[3][2], m_p[3][1], m_p[3][0]};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_w(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic set_identity();
    for (int i = 0; i < 16; i++) write_w(4'(i), (i % 5 == 0) ? 8'd1 : 8'd0);
  endtask

  task automatic start_job(input logic [7:0] cnt);
    start = 1'b1; vec_count = cnt;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 30) begin tick(); cyc++; end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 30) begin tick(); cyc++; end
  endtask

  initial begin
    // reset state
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_arr_en", arr_en, 0);
    chk("rst_load_w", arr_load_weight, 0);
    chk("rst_ifmap", arr_ifmap, 0);
    chk("rst_res_data", res_data, 0);
    rst_n = 1'b1;
    tick();

    // identity weights, single vector
    set_identity();
    start_job(8'd1);
    chk("id_load_w", arr_load_weight, 1);
    chk("id_load_en", arr_en, 1);
    chk("id_busy", busy, 1);
    tick();
    chk("id_in_ready", in_ready, 1);
    chk("id_idle_en", arr_en, 0);
    in_valid = 1'b1; in_data = {8'd4, 8'd3, 8'd2, 8'd1};
    tick();
    in_valid = 1'b0;
    wait_res(n);
    chk("id_latency", 128'(n), 7);
    chk("id_data", res_data, {24'd4, 24'd3, 24'd2, 24'd1});
    wait_done(n);
    chk("id_done", done, 1);
    tick();
    chk("id_done_pulse", done, 0);
    chk("id_idle_busy", busy, 0);

    // all-ones weights, last write coincides with start, two vectors back to back
    for (int i = 0; i < 16; i++) if (i != 1) write_w(4'(i), 8'd1);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'd1; start = 1'b1; vec_count = 8'd2;
    tick();
    wr_en = 1'b0; start = 1'b0;
    tick();
    in_valid = 1'b1; in_data = {8'd4, 8'd3, 8'd2, 8'd1};
    tick();
    in_data = {4{8'hFF}};
    tick();
    in_valid = 1'b0;
    wait_res(n);
    chk("b2b_latency", 128'(n), 6);
    chk("b2b_first", res_data, {4{24'd10}});
    tick();
    chk("b2b_second_valid", res_valid, 1);
    chk("b2b_second", res_data, {4{24'hFFFFFC}});
    wait_done(n);
    chk("b2b_done", done, 1);
    tick();

    // extreme operands: (-128)*(-128)*4 per column
    for (int i = 0; i < 16; i++) write_w(4'(i), 8'h80);
    start_job(8'd1);
    tick();
    in_valid = 1'b1; in_data = {4{8'h80}};
    tick();
    in_valid = 1'b0;
    wait_res(n);
    chk("max_data", res_data, {4{24'h010000}});
    wait_done(n);
    tick();

    // four vectors, result side held off for five cycles
    set_identity();
    start_job(8'd4);
    tick();
    in_valid = 1'b1;
    in_data = {8'd4, 8'd3, 8'd2, 8'd1};    tick();
    in_data = {8'd8, 8'd7, 8'd6, 8'd5};    tick();
    in_data = {8'd12, 8'd11, 8'd10, 8'd9}; tick();
    in_data = {8'hFC, 8'hFD, 8'hFE, 8'hFF}; tick();
    in_valid = 1'b0;
    wait_res(n);
    res_ready = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h55; start = 1'b1; vec_count = 8'd9;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", res_valid, 1);
      chk("stall_hold", res_data, {24'd4, 24'd3, 24'd2, 24'd1});
      chk("stall_arr_en", arr_en, 0);
      chk("stall_in_ready", in_ready, 0);
    end
    wr_en = 1'b0; start = 1'b0;
    chk("busy_wr_ignored", arr_weight[7:0], 8'h01);
    chk("busy_start_ignored", busy, 1);
    res_ready = 1'b1;
    chk("stall_r0", res_data, {24'd4, 24'd3, 24'd2, 24'd1});
    tick();
    chk("stall_r1", res_data, {24'd8, 24'd7, 24'd6, 24'd5});
    tick();
    chk("stall_r2", res_data, {24'd12, 24'd11, 24'd10, 24'd9});
    tick();
    chk("stall_r3", res_data, {24'hFFFFFC, 24'hFFFFFD, 24'hFFFFFE, 24'hFFFFFF});
    wait_done(n);
    chk("stall_done", done, 1);
    tick();

    // empty job
    start_job(8'd0);
    chk("zero_load_w", arr_load_weight, 1);
    tick();
    chk("zero_done", done, 1);
    chk("zero_no_res", res_valid, 0);
    tick();
    chk("zero_idle", busy, 0);

    // reset in the middle of streaming
    start_job(8'd3);
    tick();
    in_valid = 1'b1; in_data = {8'd4, 8'd3, 8'd2, 8'd1};
    tick();
    in_data = {8'd8, 8'd7, 8'd6, 8'd5};
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_arr_en", arr_en, 0);
    chk("abort_ifmap", arr_ifmap, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_load_w", arr_load_weight, 0);
    chk("abort_bank", arr_weight, 0);
    chk("abort_res_data", res_data, 0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen_done = seen_done | done;
    end
    chk("abort_no_done", seen_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
